// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver for 8N1 frames, with optional
// parity (8E1/8O1) and 5..8 data bits. The line is double-synchronised and
// each bit is sampled at mid-bit, CLKS_PER_BIT clocks apart.
//
// Ports:
//   clk        rising-edge system clock
//   rst        synchronous, active-high reset
//   rx         asynchronous serial input, idle high
//   data_out   last good byte, LSB aligned, unused MSBs zero
//   done_r     one-cycle pulse: good frame, data_out valid from this cycle
//   error      one-cycle pulse: frame_err | parity_err
//   frame_err  one-cycle pulse: stop bit sampled low
//   parity_err one-cycle pulse: parity mismatch
//   busy       high whenever a frame is in progress (from the start edge)
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       done_r,
  output logic       error,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 pmis_q, pmis_d;
  logic [7:0]           data_q, data_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;

  logic                 sync1_q, rx_s_q;
  logic [1:0]           vld_q;
  logic                 prev_q;
  logic                 start_edge;

  // prev_q only holds a 1 once the synchroniser carries a real pin sample,
  // so a line that is already low at reset exit cannot fake a start edge.
  assign start_edge = prev_q & ~rx_s_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pmis_d  = pmis_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) begin
          state_d = START;
          bit_d   = '0;
          pmis_d  = 1'b0;
        end
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_DATA) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          pmis_d  = rx_s_q != ((^shreg_q) ^ ODD);
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
            if (pmis_q) begin
              perr_d = 1'b1;
            end else begin
              done_d = 1'b1;
              data_d = 8'(shreg_q);
            end
          end else begin
            state_d = WAIT_IDLE;
            ferr_d  = 1'b1;
            perr_d  = pmis_q;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      vld_q   <= '0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pmis_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
      vld_q   <= {vld_q[0], 1'b1};
      prev_q  <= rx_s_q & vld_q[1];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pmis_q  <= pmis_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
    end
  end

  assign data_out   = data_q;
  assign done_r     = done_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign error      = ferr_q | perr_q;
  assign busy       = (state_q != IDLE) | start_edge;

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: a default 8N1 instance and an 8E1 instance.
// Frames are driven bit by bit; a frame-level model predicts outcome,
// strobe cycle and held byte from the frame contents alone.
module tb_uart_rx_core;
  localparam int C = 16;
  localparam int H = C / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic done0, err0, fe0, pe0, busy0;
  logic done1, err1, fe1, pe1, busy1;

  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst(rst), .rx(rx0), .data_out(dout0), .done_r(done0), .error(err0),
    .frame_err(fe0), .parity_err(pe0), .busy(busy0));

  uart_rx_core #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst(rst), .rx(rx1), .data_out(dout1), .done_r(done1), .error(err1),
    .frame_err(fe1), .parity_err(pe1), .busy(busy1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int w; int cyc; logic dn; logic er; logic fe; logic pe; logic [7:0] d;
  } ev_t;
  ev_t evq[$];
  int rise[2], fall[2];
  logic bprev[2] = '{1'b0, 1'b0};
  logic [7:0] exp_data[2] = '{8'h00, 8'h00};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done0 | err0) begin
      check("excl0", done0 & err0, 0);
      check("errsum0", err0, fe0 | pe0);
      evq.push_back(ev_t'{0, cyc, done0, err0, fe0, pe0, dout0});
    end
    if (done1 | err1) begin
      check("excl1", done1 & err1, 0);
      check("errsum1", err1, fe1 | pe1);
      evq.push_back(ev_t'{1, cyc, done1, err1, fe1, pe1, dout1});
    end
    if (busy0 && !bprev[0]) rise[0] = cyc;
    if (!busy0 && bprev[0]) fall[0] = cyc;
    if (busy1 && !bprev[1]) rise[1] = cyc;
    if (!busy1 && bprev[1]) fall[1] = cyc;
    bprev[0] = busy0;
    bprev[1] = busy1;
  end

  // Called and returns at posedge+1; holds line w at v for n cycles.
  task automatic drive(input int w, input logic v, input int n);
    if (w == 0) rx0 = v; else rx1 = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int w, input logic [7:0] d, input logic par,
                      input logic stp, output int t0);
    t0 = cyc;
    drive(w, 1'b0, C);
    for (int i = 0; i < 8; i++) drive(w, d[i], C);
    if (w == 1) drive(w, par, C);
    drive(w, stp, C);
  endtask

  // Frame-level model: pin low at t0 -> rx_s low at t0+2 -> stop sampled
  // H + (bits+1)*C later -> strobe one cycle after.
  task automatic expect_frame(input int w, input int t0, input logic [7:0] d,
                              input logic par, input logic stp, output int ecyc);
    int   pb;
    logic pok, good;
    ev_t  e;
    pb   = (w == 1) ? 1 : 0;
    pok  = (w == 0) ? 1'b1 : (par == ^d);
    good = stp && pok;
    ecyc = t0 + 2 + H + (8 + pb + 1) * C + 1;
    if (good) exp_data[w] = d;
    check("ev_count", evq.size(), 1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check("ev_dut", e.w, w);
      check("ev_cycle", e.cyc, ecyc);
      check("done_r", e.dn, good);
      check("frame_err", e.fe, !stp);
      check("parity_err", e.pe, !pok);
      check("data_out", e.d, exp_data[w]);
    end
    evq.delete();
  endtask

  task automatic expect_quiet(input string tag);
    check(tag, evq.size(), 0);
    evq.delete();
  endtask

  initial begin
    int t0, c1, c2, hold, gap, w;
    logic [7:0] d;
    logic par, stp;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out0", {dout0, done0, err0, fe0, pe0, busy0}, 0);
    check("reset_out1", {dout1, done1, err1, fe1, pe1, busy1}, 0);
    @(posedge clk); #1;
    drive(0, 1'b1, 5);

    // Clean 0xA5 frame; busy spans D..D+152.
    send(0, 8'hA5, 1'b0, 1'b1, t0);
    expect_frame(0, t0, 8'hA5, 1'b0, 1'b1, c1);
    check("busy_rise", rise[0], t0 + 2);
    check("busy_fall", fall[0], t0 + 2 + 153);
    drive(0, 1'b1, 10);

    // Back-to-back frames, no idle gap.
    send(0, 8'hF0, 1'b0, 1'b1, t0);
    expect_frame(0, t0, 8'hF0, 1'b0, 1'b1, c1);
    send(0, 8'h0F, 1'b0, 1'b1, t0);
    expect_frame(0, t0, 8'h0F, 1'b0, 1'b1, c2);
    check("b2b_spacing", c2 - c1, 160);
    drive(0, 1'b1, 10);

    // 4-cycle glitch: false start, back to IDLE at D+9.
    t0 = cyc;
    drive(0, 1'b0, 4);
    drive(0, 1'b1, 6);
    @(negedge clk);
    check("glitch_busy_D8", busy0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("glitch_busy_D9", busy0, 0);
    @(posedge clk); #1;
    drive(0, 1'b1, 20);
    expect_quiet("glitch_quiet");
    send(0, 8'h3C, 1'b0, 1'b1, t0);
    expect_frame(0, t0, 8'h3C, 1'b0, 1'b1, c1);
    drive(0, 1'b1, 5);

    // Stop bit low, then break held for 50 cycles.
    send(0, 8'h55, 1'b0, 1'b0, t0);
    expect_frame(0, t0, 8'h55, 1'b0, 1'b0, c1);
    drive(0, 1'b0, 50);
    check("break_busy", busy0, 1);
    expect_quiet("break_quiet");
    drive(0, 1'b1, 4);
    check("break_release_busy", busy0, 0);
    drive(0, 1'b1, 2);
    send(0, 8'h81, 1'b0, 1'b1, t0);
    expect_frame(0, t0, 8'h81, 1'b0, 1'b1, c1);
    drive(0, 1'b1, 5);

    // Even parity instance: correct then wrong parity bit.
    send(1, 8'h07, 1'b1, 1'b1, t0);
    expect_frame(1, t0, 8'h07, 1'b1, 1'b1, c1);
    drive(1, 1'b1, 5);
    send(1, 8'h07, 1'b0, 1'b1, t0);
    expect_frame(1, t0, 8'h07, 1'b0, 1'b1, c1);
    drive(1, 1'b1, 5);

    // Reset at D+80 of a 0xC3 frame.
    fork
      send(0, 8'hC3, 1'b0, 1'b1, t0);
      begin
        repeat (82) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out", {dout0, done0, err0, fe0, pe0, busy0}, 0);
      end
    join
    exp_data[0] = 8'h00;
    expect_quiet("midrst_quiet");
    drive(0, 1'b1, 5);
    send(0, 8'h99, 1'b0, 1'b1, t0);
    expect_frame(0, t0, 8'h99, 1'b0, 1'b1, c1);
    drive(0, 1'b1, 5);

    // Randomised frames on both instances.
    for (int i = 0; i < 40; i++) begin
      w   = int'($urandom_range(0, 1));
      d   = 8'($urandom);
      stp = ($urandom_range(0, 3) != 0);
      par = (w == 1) ? ((^d) ^ ($urandom_range(0, 3) == 0)) : 1'b0;
      send(w, d, par, stp, t0);
      expect_frame(w, t0, d, par, stp, c1);
      if (!stp) begin
        hold = int'($urandom_range(0, 30));
        drive(w, 1'b0, hold);
        expect_quiet("rand_break_quiet");
        drive(w, 1'b1, 3);
      end
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 20));
      if (gap > 0) drive(w, 1'b1, gap);
    end
    drive(0, 1'b1, 10);
    expect_quiet("final_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
